// File: rtl/config_pkg.sv
// Shared types and constants for the fabric configuration loader.
package config_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ISSUE,
      S_GAP,
      S_FINISH,
      S_ERR,
      S_TRAILER
   } state_e;

   localparam logic [15:0] MAGIC     = 16'hC0F6;
   localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

   localparam logic [15:0] SEC_SB  = 16'd7;
   localparam logic [15:0] SEC_CB0 = 16'd6;
   localparam logic [15:0] SEC_CB1 = 16'd5;
   localparam logic [15:0] SEC_CLB = 16'd4;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MAGIC    = 2'b01;
   localparam logic [1:0] ERR_SECTION  = 2'b10;
   localparam logic [1:0] ERR_CHECKSUM = 2'b11;

   function automatic logic [15:0] section_of(input logic [31:0] addr);
      return addr[31:16];
   endfunction

endpackage

// File: rtl/config_checksum.sv
// Running 32-bit sum over accepted record words, compared against the trailer word.
module config_checksum (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        add_en_i,
   input  logic [31:0] word_i,
   output logic        match_o
);

   logic [31:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear_i)       sum_d = '0;
      else if (add_en_i) sum_d = sum_q + word_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) sum_q <= '0;
      else         sum_q <= sum_d;
   end

   assign match_o = (word_i == sum_q);

endmodule

// File: rtl/config_loader.sv
// Host stream to config-bus sequencer for the PE-tile array.
// Define CONFIG_LOADER_CHECKSUM_EN to require a checksum trailer after the last record.
module config_loader
   import config_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter logic [15:0] MIN_SECTION = 16'd4,
   parameter logic [15:0] MAX_SECTION = 16'd7,
   parameter logic [31:0] IDLE_ADDR   = config_pkg::IDLE_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] records_done
);

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam state_e LAST_STATE =
`ifdef CONFIG_LOADER_CHECKSUM_EN
      S_TRAILER;
`else
      S_FINISH;
`endif

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d, data_q, data_d;
   logic [15:0] n_q, n_d, rec_q, rec_d;
   logic [3:0]  hold_q, hold_d;
   logic        done_q, done_d, error_q, error_d;
   logic [1:0]  err_q, err_d;
   logic        rdy_en_q;

   logic        in_hs, hdr_ok, sec_ok;
   logic [15:0] sec;

   assign busy     = state_q inside {S_ADDR, S_DATA, S_ISSUE, S_GAP, S_TRAILER};
   // Ready is held off for the first cycle after reset release.
   assign in_ready = rdy_en_q && (state_q inside {S_IDLE, S_ADDR, S_DATA, S_TRAILER});
   assign in_hs    = in_valid && in_ready;
   assign hdr_ok   = (in_data[31:16] == MAGIC);
   assign sec      = section_of(in_data);
   assign sec_ok   = (sec >= MIN_SECTION) && (sec <= MAX_SECTION);

`ifdef CONFIG_LOADER_CHECKSUM_EN
   logic sum_match;

   config_checksum u_checksum (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (in_hs && state_q == S_IDLE && hdr_ok),
      .add_en_i(in_hs && (state_q == S_ADDR || state_q == S_DATA)),
      .word_i  (in_data),
      .match_o (sum_match)
   );
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      n_d     = n_q;
      rec_d   = rec_q;
      hold_d  = hold_q;
      done_d  = done_q;
      error_d = error_q;
      err_d   = err_q;

      if (clear && busy) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (in_hs) begin
               if (hdr_ok) begin
                  done_d  = 1'b0;
                  rec_d   = '0;
                  n_d     = in_data[15:0];
                  state_d = (in_data[15:0] == 16'd0) ? LAST_STATE : S_ADDR;
               end else begin
                  err_d   = ERR_MAGIC;
                  state_d = S_ERR;
               end
            end
            S_ADDR: if (in_hs) begin
               addr_d = in_data;
               if (sec_ok) begin
                  state_d = S_DATA;
               end else begin
                  err_d   = ERR_SECTION;
                  state_d = S_ERR;
               end
            end
            S_DATA: if (in_hs) begin
               data_d  = in_data;
               hold_d  = '0;
               state_d = S_ISSUE;
            end
            S_ISSUE: begin
               if (hold_q == HOLD_LAST) state_d = S_GAP;
               else                     hold_d  = hold_q + 4'd1;
            end
            S_GAP: begin
               rec_d   = rec_q + 16'd1;
               state_d = (rec_d == n_q) ? LAST_STATE : S_ADDR;
            end
            S_FINISH: state_d = S_IDLE;
            S_ERR: if (clear) begin
               error_d = 1'b0;
               err_d   = ERR_NONE;
               state_d = S_IDLE;
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            S_TRAILER: if (in_hs) begin
               if (sum_match) begin
                  state_d = S_FINISH;
               end else begin
                  err_d   = ERR_CHECKSUM;
                  state_d = S_ERR;
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end

      if (state_d == S_FINISH) done_d  = 1'b1;
      if (state_d == S_ERR)    error_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         n_q      <= '0;
         rec_q    <= '0;
         hold_q   <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         err_q    <= ERR_NONE;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         n_q      <= n_d;
         rec_q    <= rec_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         error_q  <= error_d;
         err_q    <= err_d;
         rdy_en_q <= 1'b1;
      end
   end

   // Bus is decoded from state so an async reset parks it at IDLE_ADDR without a clock.
   assign config_addr  = (state_q == S_ISSUE) ? addr_q : IDLE_ADDR;
   assign config_data  = (state_q == S_ISSUE) ? data_q : '0;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_q;
   assign records_done = rec_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: instance 0 uses HOLD_CYCLES=1, instance 1 uses HOLD_CYCLES=3.
module tb_config_loader;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          len;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [1:0] clear = '0, in_valid = '0;
   logic [1:0][31:0] in_data = '0;
   logic [1:0] in_ready, busy, done, error;
   logic [1:0][31:0] cfg_addr, cfg_data;
   logic [1:0][1:0] err_code;
   logic [1:0][15:0] records;

   int n_vec = 0;
   int n_err = 0;

   wr_t exp_q0[$];
   wr_t exp_q1[$];
   logic [31:0] rec_addr[4];
   logic [31:0] rec_data[4];

   logic [1:0][31:0] run_addr, run_data;
   int run_len[2];
   bit in_run[2];

   always #5 clk = ~clk;

   config_loader #(.HOLD_CYCLES(1)) u_dut_h1 (
      .clk(clk), .reset(reset), .clear(clear[0]), .in_data(in_data[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .config_addr(cfg_addr[0]),
      .config_data(cfg_data[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
      .err_code(err_code[0]), .records_done(records[0])
   );

   config_loader #(.HOLD_CYCLES(3)) u_dut_h3 (
      .clk(clk), .reset(reset), .clear(clear[1]), .in_data(in_data[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .config_addr(cfg_addr[1]),
      .config_data(cfg_data[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
      .err_code(err_code[1]), .records_done(records[1])
   );

   function automatic int hold_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic void push_exp(input int d, input logic [31:0] a, input logic [31:0] v, input int len);
      wr_t w;
      w = '{addr: a, data: v, len: len};
      if (d == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
   endfunction

   function automatic int exp_size(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // Scoreboard: a bus write is a run of identical non-idle addresses, closed when the address changes.
   task automatic close_run(input int d);
      wr_t w;
      n_vec++;
      if (exp_size(d) == 0) begin
         n_err++;
         $display("FAIL unexpected_write dut%0d: got addr=%h data=%h len=%0d, required no write",
                  d, run_addr[d], run_data[d], run_len[d]);
      end else begin
         w = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         if (run_addr[d] !== w.addr || run_data[d] !== w.data || run_len[d] != w.len) begin
            n_err++;
            $display("FAIL bus_write dut%0d: got addr=%h data=%h len=%0d, required addr=%h data=%h len=%0d",
                     d, run_addr[d], run_data[d], run_len[d], w.addr, w.data, w.len);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (cfg_addr[d] !== IDLE) begin
            if (in_run[d] && cfg_addr[d] === run_addr[d]) begin
               run_len[d]++;
            end else begin
               if (in_run[d]) close_run(d);
               in_run[d]   = 1'b1;
               run_addr[d] = cfg_addr[d];
               run_data[d] = cfg_data[d];
               run_len[d]  = 1;
            end
         end else if (in_run[d]) begin
            close_run(d);
            in_run[d] = 1'b0;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the word transferred.
   task automatic send_word(input int d, input logic [31:0] w, output int waited);
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      waited = 0;
      while (in_ready[d] !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready[d] !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL handshake_timeout dut%0d: in_ready=%b after %0d cycles, required 1", d, in_ready[d], waited);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic run_load(input int d, input logic [31:0] hdr, input int n, input bit good_trailer,
                           output int rec2_wait);
      int w;
      logic [31:0] sum;
      sum = '0;
      rec2_wait = -1;
      send_word(d, hdr, w);
      for (int i = 0; i < n; i++) begin
         send_word(d, rec_addr[i], w);
         if (i == 1) rec2_wait = w;
         push_exp(d, rec_addr[i], rec_data[i], hold_of(d));
         send_word(d, rec_data[i], w);
         sum = sum + rec_addr[i] + rec_data[i];
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      send_word(d, good_trailer ? sum : sum + 32'd1, w);
`else
      if (!good_trailer) sum = '0;
`endif
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_end(input int d);
      int c;
      c = 0;
      while (done[d] !== 1'b1 && error[d] !== 1'b1 && c < 60) begin
         @(negedge clk);
         c++;
      end
      n_vec++;
      if (c >= 60) begin
         n_err++;
         $display("FAIL load_timeout dut%0d: done=%b error=%b, required done or error within 60 cycles",
                  d, done[d], error[d]);
      end
   endtask

   task automatic pulse_clear(input int d);
      clear[d] = 1'b1;
      @(negedge clk);
      clear[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [85:0] got, req;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      req = {IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0};
      for (int d = 0; d < 2; d++) begin
         got = {cfg_addr[d], cfg_data[d], in_ready[d], busy[d], done[d], error[d], err_code[d], records[d]};
         n_vec++;
         if (got !== req) begin
            n_err++;
            $display("FAIL reset_state dut%0d: got %h, required %h", d, got, req);
         end
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 2'b00) begin
         n_err++;
         $display("FAIL ready_at_release: got in_ready=%b, required 00", in_ready);
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== 2'b11) begin
         n_err++;
         $display("FAIL ready_after_first_clock: got in_ready=%b, required 11", in_ready);
      end
   endtask

   task automatic test_good_load();
      int w;
      rec_addr[0] = 32'h0007_0003; rec_data[0] = 32'h0000_0005;
      rec_addr[1] = 32'h0004_0003; rec_data[1] = 32'h0000_0002;
      run_load(0, 32'hC0F6_0002, 2, 1'b1, w);
      n_vec++;
      if (w != 2) begin
         n_err++;
         $display("FAIL good_load_backpressure: got %0d wait cycles, required 2", w);
      end
      wait_end(0);
      n_vec++;
      if ({done[0], error[0], busy[0], records[0]} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
         n_err++;
         $display("FAIL good_load_status: got done=%b error=%b busy=%b records=%0d, required 1 0 0 2",
                  done[0], error[0], busy[0], records[0]);
      end
      n_vec++;
      if (exp_q0.size() != 0) begin
         n_err++;
         $display("FAIL good_load_writes: got %0d writes missing, required 0", exp_q0.size());
      end
   endtask

   task automatic test_bad_magic();
      int w;
      send_word(0, 32'h1234_0001, w);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({error[0], err_code[0], in_ready[0], busy[0]} !== {1'b1, 2'b01, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL bad_magic_err: got error=%b code=%b ready=%b busy=%b, required 1 01 0 0",
                  error[0], err_code[0], in_ready[0], busy[0]);
      end
      pulse_clear(0);
      n_vec++;
      if ({in_ready[0], error[0], err_code[0]} !== {1'b1, 1'b0, 2'b00}) begin
         n_err++;
         $display("FAIL bad_magic_clear: got ready=%b error=%b code=%b, required 1 0 00",
                  in_ready[0], error[0], err_code[0]);
      end
   endtask

   task automatic test_bad_section();
      int w;
      send_word(0, 32'hC0F6_0001, w);
      send_word(0, 32'h0003_0001, w);
      in_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({error[0], err_code[0], records[0], in_ready[0]} !== {1'b1, 2'b10, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL bad_section: got error=%b code=%b records=%0d ready=%b, required 1 10 0 0",
                  error[0], err_code[0], records[0], in_ready[0]);
      end
      pulse_clear(0);
   endtask

   task automatic test_back_to_back();
      int w;
      rec_addr[0] = 32'h0007_0010; rec_data[0] = 32'hAAAA_0001;
      rec_addr[1] = 32'h0006_0011; rec_data[1] = 32'hBBBB_0002;
      run_load(1, 32'hC0F6_0002, 2, 1'b1, w);
      n_vec++;
      if (w != 4) begin
         n_err++;
         $display("FAIL hold3_backpressure: got %0d wait cycles, required 4", w);
      end
      wait_end(1);
      n_vec++;
      if ({done[1], records[1]} !== {1'b1, 16'd2} || exp_q1.size() != 0) begin
         n_err++;
         $display("FAIL hold3_status: got done=%b records=%0d pending=%0d, required 1 2 0",
                  done[1], records[1], exp_q1.size());
      end
   endtask

   task automatic test_abort();
      int w;
      send_word(1, 32'hC0F6_0003, w);
      send_word(1, 32'h0005_0001, w);
      push_exp(1, 32'h0005_0001, 32'h0000_0011, 3);
      send_word(1, 32'h0000_0011, w);
      send_word(1, 32'h0006_0002, w);
      push_exp(1, 32'h0006_0002, 32'h0000_0022, 1);
      send_word(1, 32'h0000_0022, w);
      in_valid[1] = 1'b0;
      pulse_clear(1);
      n_vec++;
      if ({in_ready[1], cfg_addr[1], busy[1], done[1], records[1]} !== {1'b1, IDLE, 1'b0, 1'b0, 16'd1}) begin
         n_err++;
         $display("FAIL abort: got ready=%b addr=%h busy=%b done=%b records=%0d, required 1 %h 0 0 1",
                  in_ready[1], cfg_addr[1], busy[1], done[1], records[1], IDLE);
      end
      @(negedge clk);
      n_vec++;
      if (exp_q1.size() != 0) begin
         n_err++;
         $display("FAIL abort_writes: got %0d writes missing, required 0", exp_q1.size());
      end
   endtask

   task automatic test_zero_records();
      int w;
      run_load(0, 32'hC0F6_0000, 0, 1'b1, w);
      wait_end(0);
      n_vec++;
      if ({done[0], error[0], records[0]} !== {1'b1, 1'b0, 16'd0}) begin
         n_err++;
         $display("FAIL zero_records: got done=%b error=%b records=%0d, required 1 0 0",
                  done[0], error[0], records[0]);
      end
   endtask

`ifdef CONFIG_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int w;
      rec_addr[0] = 32'h0005_0002; rec_data[0] = 32'h0000_0001;
      run_load(0, 32'hC0F6_0001, 1, 1'b1, w);
      wait_end(0);
      n_vec++;
      if ({done[0], error[0]} !== 2'b10) begin
         n_err++;
         $display("FAIL checksum_good: got done=%b error=%b, required 1 0", done[0], error[0]);
      end
      run_load(0, 32'hC0F6_0001, 1, 1'b0, w);
      wait_end(0);
      n_vec++;
      if ({error[0], err_code[0]} !== {1'b1, 2'b11}) begin
         n_err++;
         $display("FAIL checksum_bad: got error=%b code=%b, required 1 11", error[0], err_code[0]);
      end
      pulse_clear(0);
   endtask
`endif

   task automatic test_async_reset();
      int w;
      send_word(1, 32'hC0F6_0001, w);
      send_word(1, 32'h0004_0020, w);
      push_exp(1, 32'h0004_0020, 32'h1234_5678, 1);
      send_word(1, 32'h1234_5678, w);
      in_valid[1] = 1'b0;
      n_vec++;
      if (cfg_addr[1] !== 32'h0004_0020) begin
         n_err++;
         $display("FAIL issue_before_reset: got addr=%h, required 00040020", cfg_addr[1]);
      end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({cfg_addr[1], busy[1]} !== {IDLE, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset_bus: got addr=%h busy=%b, required %h 0", cfg_addr[1], busy[1], IDLE);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 2'b11 || exp_q1.size() != 0) begin
         n_err++;
         $display("FAIL after_async_reset: got in_ready=%b pending=%0d, required 11 0", in_ready, exp_q1.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      test_reset();
      test_good_load();
      test_bad_magic();
      test_bad_section();
      test_back_to_back();
      test_abort();
      test_zero_records();
`ifdef CONFIG_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_async_reset();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Sequences fabric configuration for the PE-tile array.
- Consumes a host word stream via a valid/ready handshake, validates it, and drives the shared config_addr/config_data broadcast bus that every tile decodes, one write at a time.
- Sits between the host/bitstream source and the tile array; it is the only driver of the config bus.
- Config address format: config_addr[15:0] = tile_id, config_addr[31:16] = section (7 = switch box, 6 = cb0, 5 = cb1, 4 = compute block).

Parameters:
- HOLD_CYCLES, 1: cycles each write is held on the bus (1..15).
- MIN_SECTION, 4: lowest legal section code.
- MAX_SECTION, 7: highest legal section code.
- IDLE_ADDR, 32'hFFFF_FFFF: bus address driven when no write is active; matches no tile.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort/acknowledge pulse.
- in_data  in  32  host stream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- config_addr  out  32  broadcast config address.
- config_data  out  32  broadcast config data.
- busy  out  1  a load is in progress.
- done  out  1  last load completed cleanly (sticky).
- error  out  1  load failed (sticky).
- err_code  out  2  01 bad magic, 10 bad section, 11 checksum mismatch.
- records_done  out  16  writes issued in the current/last load.

Behaviour:
- Reset: asynchronous and active-high. It forces state IDLE, config_addr=IDLE_ADDR, config_data=0, in_ready=0, busy=0, done=0, error=0, err_code=0, records_done=0.
  - in_ready rises on the first clock after reset deasserts.
  - Reset mid-write returns the bus to IDLE_ADDR immediately, with no clock needed.
- Handshake: a word transfers on a clk edge where in_valid && in_ready. A word offered while in_ready=0 is not consumed; the host holds it.
- Stream format:
  - Header word: [31:16] = magic 16'hC0F6, [15:0] = N.
  - Then N records of two words each: address word, then data word.
- State IDLE (done/error retain their values): in_ready=1.
  - Header accepted with a good magic: if N>0 go to ADDR, set busy=1, clear done and records_done, latch N.
  - Bad magic: go to ERR, err_code=01.
- ADDR: in_ready=1. Capture the address word.
  - Section outside [MIN_SECTION, MAX_SECTION]: go to ERR, err_code=10. No write is issued.
  - Otherwise go to DATA.
- DATA: in_ready=1. Capture the data word, then go to ISSUE.
- ISSUE: in_ready=0. config_addr/config_data are driven from registers for exactly HOLD_CYCLES cycles, then go to GAP.
- GAP: in_ready=0. Drive IDLE_ADDR for one cycle; records_done increments at this edge.
  - If records_done now equals N: go to FINISH (or TRAILER when checksum is enabled).
  - Otherwise go to ADDR.
- FINISH: busy=0, done=1, go to IDLE.
- N=0: the header goes straight to FINISH (or TRAILER), with no bus activity.
- ERR: in_ready=0, busy=0, error=1. The state holds until clear; clear returns to IDLE and zeroes error and err_code.
- clear in any busy state aborts:
  - Next cycle is IDLE, the bus is at IDLE_ADDR, busy=0, done=0.
  - records_done keeps the count of completed writes.
  - A write in ISSUE is truncated.
- Minimum record throughput: 2 + HOLD_CYCLES + 1 cycles when in_valid stays high.
- Tiles see each write as exactly HOLD_CYCLES consecutive cycles of matching address, so every config register captures it.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit running sum (mod 2^32) covers every address and data word accepted.
  - After the last record, state TRAILER (in_ready=1) accepts one more word.
  - Trailer equal to the sum: go to FINISH. Mismatch: go to ERR, err_code=11.
  - The sum clears on header accept and on reset.
- Without the macro: no TRAILER state and no adder; err_code 11 is never produced.

Decomposition:
- Shared package config_pkg holds:
  - the state enum;
  - the MAGIC constant;
  - IDLE_ADDR;
  - the section codes SEC_SB=7, SEC_CB0=6, SEC_CB1=5, SEC_CLB=4;
  - the err_code constants;
  - a section-field extract function.
- One sub-module is natural: config_checksum (accumulator plus compare), instantiated only under CONFIG_LOADER_CHECKSUM_EN. The FSM stays in config_loader.

Test Plan:
- Good load: stream C0F6_0002, 0007_0003/0000_0005, 0004_0003/0000_0002, HOLD_CYCLES=1. Required:
  - config_addr=0007_0003 with data 5 for exactly 1 cycle, then FFFF_FFFF.
  - config_addr=0004_0003 with data 2 for exactly 1 cycle.
  - done=1, records_done=2, busy=0.
- Bad magic: header 1234_0001 -> error=1, err_code=01, in_ready=0, bus never leaves FFFF_FFFF. Then clear -> in_ready=1, error=0.
- Bad section: header C0F6_0001, address 0003_0001 -> err_code=10, no bus write, records_done=0.
- Backpressure and hold: HOLD_CYCLES=3, in_valid held high through 2 records -> in_ready low for 4 cycles per record; each address is on the bus for exactly 3 cycles.
- Abort and reset: clear during the ISSUE of record 2 of 3 -> next cycle IDLE, bus FFFF_FFFF, records_done=1. Async reset pulse mid-ISSUE -> bus FFFF_FFFF before the next edge.
- Checksum (macro on), 1 record 0005_0002/0000_0001:
  - trailer 0005_0003 -> done=1;
  - trailer 0005_0004 -> err_code=11.
